uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver front end that sits directly upstream of the sequential processor.
- Takes the board rx pin, oversamples at 16x the baud rate, and deframes 8N1 characters.
- Pushes each good byte into a small first-word-fall-through FIFO.
- The processor pops bytes with a one-cycle rd strobe; framing and overrun errors are flagged sticky until cleared.

Parameters:
- CLK_DIV, 326: clock cycles per oversample tick (50 MHz / (9600*16), rounded).
- DBIT, 8: data bits per character, LSB first.
- SB_TICK, 16: oversample ticks spent in the stop bit.
- FIFO_AW, 2: FIFO address width; depth = 2**FIFO_AW.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx  in  1  raw serial input, idles high, asynchronous to clk.
- rd  in  1  pop strobe, one cycle per byte.
- err_clr  in  1  clears frame_err and overrun.
- rx_data  out  DBIT  byte at FIFO head, valid while rx_empty=0.
- rx_empty  out  1  FIFO holds no bytes.
- rx_full  out  1  FIFO holds 2**FIFO_AW bytes.
- frame_err  out  1  sticky: stop bit sampled low.
- overrun  out  1  sticky: good byte arrived while FIFO full, byte dropped.

Behaviour:
- Reset (reset=0, asynchronous) forces the following; release is synchronous to clk.
  - Outputs: rx_data=0, rx_empty=1, rx_full=0, frame_err=0, overrun=0.
  - Internal state: synchronizer flops=1, FSM=IDLE, all counters and pointers=0.
- Synchronizer: rx passes through 2 flops to give rx_s; only rx_s is used downstream.
- Tick generator:
  - Free-running counter 0..CLK_DIV-1, wraps to 0.
  - tick=1 for one cycle when the counter equals CLK_DIV-1.
  - The counter is never reset by the FSM.
- FSM states IDLE, START, DATA, STOP; s is a 4-bit tick counter, n counts bits, b is the DBIT shift register.
  - IDLE: on rx_s=0 -> START, s=0. Ticks are ignored in IDLE.
  - START: each tick s++. At tick with s=7 (mid start bit):
    - rx_s=0 -> DATA, s=0, n=0.
    - rx_s=1 -> IDLE (glitch rejected; no flag raised).
  - DATA: each tick s++. At tick with s=15:
    - b = {rx_s, b[DBIT-1:1]}, s=0.
    - If n=DBIT-1 -> STOP, else n++.
  - STOP: each tick s++. At tick with s=SB_TICK-1 -> IDLE, and:
    - rx_s=1, FIFO not full -> push b.
    - rx_s=1, FIFO full -> byte dropped, overrun=1.
    - rx_s=0 -> byte discarded, frame_err=1.
    - A low stop line is not treated as a new start: the FSM returns to IDLE and re-detects the next falling level normally.
- FIFO:
  - Depth 2**FIFO_AW, pointers FIFO_AW bits wide and wrap naturally; full/empty tracked by flags, not pointer compare.
  - rx_data = mem[rd_ptr] combinationally (first-word fall-through).
  - Push: write at wr_ptr, wr_ptr++, rx_empty=0 next cycle. rx_full=1 when wr_ptr+1 equals rd_ptr.
  - Pop (rd=1 and rx_empty=0): rd_ptr++, rx_full=0. rx_empty=1 when rd_ptr+1 equals wr_ptr.
  - rd while empty: ignored; pointers and flags unchanged.
  - Push and pop in the same cycle:
    - Not empty (including full): both pointers advance, flags unchanged, no overrun.
    - Empty: push only.
- Latency: rx_empty falls 1 clk after the stop-bit sample tick; total ≈ 9.5 bit times from the start-bit falling edge, plus 2 synchronizer cycles.
- Sticky flags:
  - err_clr=1 clears frame_err and overrun next cycle.
  - If err_clr and a new error occur in the same cycle, the flag is set (set wins).
- Reset asserted mid-character: the partial byte is lost, the FIFO is emptied, and no flag is raised.

Test Plan:
- Use CLK_DIV=4 for all scenarios. Send 0xA5 as 8N1 with bit period 64 clk -> rx_empty falls once; rx_data=0xA5; pulse rd -> rx_empty=1; both flags stay 0.
- 15-clk low pulse on idle rx, then idle high -> FSM returns to IDLE; FIFO stays empty; no flags.
- Send 0x3C with stop bit driven low -> FIFO stays empty; frame_err=1. Pulse err_clr -> frame_err=0 next cycle. Then send 0x55 normally -> rx_data=0x55.
- With FIFO_AW=2, send 0x01,0x02,0x03,0x04 without rd -> rx_full=1. Send 0x05 -> overrun=1. Pop 4 times -> 0x01..0x04 in order, then rx_empty=1; 0x05 never appears.
- FIFO full, rd asserted in the same cycle as the stop-bit push of 0x06 -> no overrun; rx_full stays 1; pops yield 0x02,0x03,0x04,0x06.
- Assert reset for 3 clk midway through the data bits of 0x77, then send 0x88 -> only 0x88 is received; all flags 0.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Processor-facing signal bundle of the UART receiver: serial line in,
// pop strobe and error clear in, FIFO head byte and status flags out.
interface uart_rx_fifo_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic            rd;
    logic            err_clr;
    logic [DBIT-1:0] rx_data;
    logic            rx_empty;
    logic            rx_full;
    logic            frame_err;
    logic            overrun;

    // The receiver block itself
    modport slave (
        input  rx, rd, err_clr,
        output rx_data, rx_empty, rx_full, frame_err, overrun
    );

    // Whoever drives the serial line and consumes the bytes
    modport master (
        output rx, rd, err_clr,
        input  rx_data, rx_empty, rx_full, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with 16x oversampling, feeding a small first-word-fall-through
// FIFO. Framing errors and overruns are reported through sticky flags that stay
// set until err_clr is pulsed.
module uart_rx_fifo #(
    parameter int CLK_DIV = 326,
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int FIFO_AW = 2
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_fifo_if.slave  bus
);
    localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic                sync1_q, sync2_q;
    logic                rxS;
    logic [CW-1:0]       tickCnt_q;
    logic                tick;

    state_t              state_q, state_d;
    logic [3:0]          s_q, s_d;
    logic [NW-1:0]       n_q, n_d;
    logic [DBIT-1:0]     b_q, b_d;
    logic                charGood;
    logic                charBad;
    logic                stopSample;

    logic [DBIT-1:0]     mem_q [DEPTH];
    logic [FIFO_AW-1:0]  wrPtr_q, rdPtr_q;
    logic [FIFO_AW-1:0]  wrPtrInc, rdPtrInc;
    logic                empty_q, full_q;
    logic                push, pop;
    logic                frameErr_q, overrun_q;

    assign rxS = sync2_q;

    // Two-flop synchronizer for the asynchronous serial line; idles high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.rx;
            sync2_q <= sync1_q;
        end
    end

    // Free-running oversample divider, independent of the receiver FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tickCnt_q <= '0;
        end else if (tickCnt_q == CW'(CLK_DIV - 1)) begin
            tickCnt_q <= '0;
        end else begin
            tickCnt_q <= tickCnt_q + CW'(1);
        end
    end

    assign tick = (tickCnt_q == CW'(CLK_DIV - 1));

    // Receiver FSM state, tick counter, bit counter and shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
        end
    end

    // Deframing: find start bit centre, sample each data bit centre, judge the stop bit
    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        n_d        = n_q;
        b_d        = b_q;
        charGood   = 1'b0;
        charBad    = 1'b0;
        stopSample = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxS) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        if (!rxS) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        s_d = '0;
                        b_d = {rxS, b_q[DBIT-1:1]};
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == 4'(SB_TICK - 1)) begin
                        state_d    = IDLE;
                        stopSample = 1'b1;
                        charGood   = rxS;
                        charBad    = !rxS;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pop      = bus.rd && !empty_q;
    assign push     = charGood && (!full_q || pop);
    assign wrPtrInc = wrPtr_q + FIFO_AW'(1);
    assign rdPtrInc = rdPtr_q + FIFO_AW'(1);

    // FIFO storage, pointers and flags; a push into a full FIFO is only accepted alongside a pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wrPtr_q] <= b_q;
            end
            if (push && pop) begin
                wrPtr_q <= wrPtrInc;
                rdPtr_q <= rdPtrInc;
            end else if (push) begin
                wrPtr_q <= wrPtrInc;
                empty_q <= 1'b0;
                full_q  <= (wrPtrInc == rdPtr_q);
            end else if (pop) begin
                rdPtr_q <= rdPtrInc;
                full_q  <= 1'b0;
                empty_q <= (rdPtrInc == wrPtr_q);
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (charBad) begin
                frameErr_q <= 1'b1;
            end else if (bus.err_clr) begin
                frameErr_q <= 1'b0;
            end
            if (charGood && full_q && !pop) begin
                overrun_q <= 1'b1;
            end else if (bus.err_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data   = mem_q[rdPtr_q];
    assign bus.rx_empty  = empty_q;
    assign bus.rx_full   = full_q;
    assign bus.frame_err = frameErr_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a fast oversample divider (4 clk per tick,
// so one bit period is 64 clk). Expected bytes and flags are hand-derived.
module tb_uart_rx_fifo;
    localparam int BIT_CLK = 64;

    logic clk;
    logic reset;
    int   checkCount;
    int   failCount;

    uart_rx_fifo_if #(.DBIT(8)) bus ();

    uart_rx_fifo #(
        .CLK_DIV(4),
        .DBIT   (8),
        .SB_TICK(16),
        .FIFO_AW(2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    // 10 ns system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check, reports any disagreement
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one 8N1 character; a low stop bit is held long enough to cover its centre sample
    task automatic applyStimulus(input logic [7:0] data, input bit stopLow);
        @(negedge clk) bus.rx = 1'b0;
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = data[i];
            repeat (BIT_CLK) @(negedge clk);
        end
        if (stopLow) begin
            bus.rx = 1'b0;
            repeat (40) @(negedge clk);
            bus.rx = 1'b1;
            repeat (BIT_CLK - 40) @(negedge clk);
        end else begin
            bus.rx = 1'b1;
            repeat (BIT_CLK) @(negedge clk);
        end
        repeat (80) @(negedge clk);
    endtask

    // Check the head byte, then pop it with a one-cycle strobe
    task automatic popByte(input string tag, input logic [7:0] exp);
        @(negedge clk);
        checkOutput(tag, 32'(bus.rx_data), 32'(exp));
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
    endtask

    // One-cycle pulse on err_clr
    task automatic clearErrors();
        @(negedge clk) bus.err_clr = 1'b1;
        @(negedge clk) bus.err_clr = 1'b0;
    endtask

    // Raise rd for exactly the cycle in which the stop bit is judged
    task automatic popAtPush();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (dut.stopSample) found = 1'b1;
        end
        if (found) begin
            bus.rd = 1'b1;
            @(negedge clk);
            bus.rd = 1'b0;
        end else begin
            checkOutput("pushWindowTimeout", 32'd0, 32'd1);
        end
    endtask

    initial begin
        checkCount  = 0;
        failCount   = 0;
        reset       = 1'b0;
        bus.rx      = 1'b1;
        bus.rd      = 1'b0;
        bus.err_clr = 1'b0;

        // Reset state
        repeat (5) @(negedge clk);
        checkOutput("rstData",  32'(bus.rx_data),   32'h0);
        checkOutput("rstEmpty", 32'(bus.rx_empty),  32'h1);
        checkOutput("rstFull",  32'(bus.rx_full),   32'h0);
        checkOutput("rstFrame", 32'(bus.frame_err), 32'h0);
        checkOutput("rstOvr",   32'(bus.overrun),   32'h0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // Single good character
        applyStimulus(8'hA5, 1'b0);
        checkOutput("a5Empty", 32'(bus.rx_empty), 32'h0);
        popByte("a5Data", 8'hA5);
        checkOutput("a5EmptyAfterPop", 32'(bus.rx_empty), 32'h1);
        checkOutput("a5Frame", 32'(bus.frame_err), 32'h0);
        checkOutput("a5Ovr",   32'(bus.overrun),   32'h0);

        // Short glitch on the idle line is rejected
        @(negedge clk) bus.rx = 1'b0;
        repeat (15) @(negedge clk);
        bus.rx = 1'b1;
        repeat (200) @(negedge clk);
        checkOutput("glitchEmpty", 32'(bus.rx_empty),  32'h1);
        checkOutput("glitchFrame", 32'(bus.frame_err), 32'h0);
        checkOutput("glitchOvr",   32'(bus.overrun),   32'h0);

        // Framing error, clear, then a good character
        applyStimulus(8'h3C, 1'b1);
        checkOutput("ferrEmpty", 32'(bus.rx_empty),  32'h1);
        checkOutput("ferrSet",   32'(bus.frame_err), 32'h1);
        clearErrors();
        checkOutput("ferrClr", 32'(bus.frame_err), 32'h0);
        applyStimulus(8'h55, 1'b0);
        checkOutput("x55Empty", 32'(bus.rx_empty), 32'h0);
        popByte("x55Data", 8'h55);
        checkOutput("x55EmptyAfterPop", 32'(bus.rx_empty), 32'h1);

        // Fill the FIFO, then overrun it
        for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b0);
        checkOutput("fillFull", 32'(bus.rx_full), 32'h1);
        checkOutput("fillOvr",  32'(bus.overrun), 32'h0);
        applyStimulus(8'h05, 1'b0);
        checkOutput("ovrSet",  32'(bus.overrun), 32'h1);
        checkOutput("ovrFull", 32'(bus.rx_full), 32'h1);
        popByte("ovrPop1", 8'h01);
        checkOutput("ovrFullAfterPop", 32'(bus.rx_full), 32'h0);
        popByte("ovrPop2", 8'h02);
        popByte("ovrPop3", 8'h03);
        popByte("ovrPop4", 8'h04);
        @(negedge clk);
        checkOutput("ovrDrained", 32'(bus.rx_empty), 32'h1);
        clearErrors();
        checkOutput("ovrClr", 32'(bus.overrun), 32'h0);

        // Full FIFO with a pop coinciding with the push
        for (int i = 1; i <= 4; i++) applyStimulus(8'(i), 1'b0);
        checkOutput("simFull", 32'(bus.rx_full), 32'h1);
        fork
            applyStimulus(8'h06, 1'b0);
            popAtPush();
        join
        checkOutput("simOvr",  32'(bus.overrun), 32'h0);
        checkOutput("simFullKept", 32'(bus.rx_full), 32'h1);
        popByte("simPop1", 8'h02);
        popByte("simPop2", 8'h03);
        popByte("simPop3", 8'h04);
        popByte("simPop4", 8'h06);
        @(negedge clk);
        checkOutput("simDrained", 32'(bus.rx_empty), 32'h1);

        // Reset in the middle of a character, with a byte already queued
        applyStimulus(8'h11, 1'b0);
        checkOutput("preRstEmpty", 32'(bus.rx_empty), 32'h0);
        fork
            applyStimulus(8'h77, 1'b0);
            begin
                repeat (1 + BIT_CLK * 8 + 48) @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                checkOutput("midRstEmpty", 32'(bus.rx_empty), 32'h1);
                checkOutput("midRstData",  32'(bus.rx_data),  32'h0);
                repeat (2) @(negedge clk);
                reset = 1'b1;
            end
        join
        checkOutput("postRstEmpty", 32'(bus.rx_empty),  32'h1);
        checkOutput("postRstFrame", 32'(bus.frame_err), 32'h0);
        applyStimulus(8'h88, 1'b0);
        checkOutput("x88Empty", 32'(bus.rx_empty), 32'h0);
        popByte("x88Data", 8'h88);
        @(negedge clk);
        checkOutput("x88Drained", 32'(bus.rx_empty),  32'h1);
        checkOutput("x88Frame",   32'(bus.frame_err), 32'h0);
        checkOutput("x88Ovr",     32'(bus.overrun),   32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
